// File: rtl/queue_ctrl_7x65.sv
// ============================================================================
// Module      : queue_ctrl_7x65
// Description : Ready/valid FIFO controller in front of an external two-port
//               DEPTH x WIDTH RAM. It owns the pointers, occupancy and
//               handshakes. The RAM only stores data.
//               Write port: driven from the enqueue side.
//               Read port : addressed by the head pointer. The read is
//                           combinational, so read data is the dequeue payload.
// Ports       :
//   clock, reset          - single clock, synchronous active-high reset
//   io_enq_valid/ready    - enqueue handshake
//   io_enq_bits           - enqueue payload
//   io_deq_valid/ready    - dequeue handshake
//   io_deq_bits           - head payload, taken straight from ram_R0_data
//   io_count              - occupancy, 0..DEPTH
//   ram_W0_addr/en/data   - RAM write port
//   ram_R0_addr/en        - RAM read port controls
//   ram_R0_data           - RAM read data, combinational from ram_R0_addr
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module queue_ctrl_7x65 #(
  parameter int DEPTH  = 7,
  parameter int WIDTH  = 65,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_enq_valid,
  output logic              io_enq_ready,
  input  logic [WIDTH-1:0]  io_enq_bits,
  output logic              io_deq_valid,
  input  logic              io_deq_ready,
  output logic [WIDTH-1:0]  io_deq_bits,
  output logic [ADDR_W-1:0] io_count,
  output logic [ADDR_W-1:0] ram_W0_addr,
  output logic              ram_W0_en,
  output logic [WIDTH-1:0]  ram_W0_data,
  output logic [ADDR_W-1:0] ram_R0_addr,
  output logic              ram_R0_en,
  input  logic [WIDTH-1:0]  ram_R0_data
);

  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] r_enq_ptr;
  logic [ADDR_W-1:0] r_deq_ptr;
  logic              r_maybe_full;

  logic              w_ptr_match;
  logic              w_empty;
  logic              w_full;
  logic              w_do_enq;
  logic              w_do_deq;
  logic [ADDR_W-1:0] w_enq_ptr_nxt;
  logic [ADDR_W-1:0] w_deq_ptr_nxt;
  logic [ADDR_W-1:0] w_count;

  // The status decode depends only on registered state, so ready never
  // depends combinationally on valid.
  assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match &  r_maybe_full;

  // Reset masks both handshakes. No write can start during reset, and no
  // stale head is presented while the pointers are being cleared.
  assign io_enq_ready = ~w_full  & ~reset;
  assign io_deq_valid = ~w_empty & ~reset;

  assign w_do_enq = io_enq_valid & io_enq_ready;
  assign w_do_deq = io_deq_valid & io_deq_ready;

  // The wrap at DEPTH-1 is explicit because DEPTH need not be a power of
  // two. Index DEPTH is never produced.
  assign w_enq_ptr_nxt = (r_enq_ptr == c_LAST) ? '0 : r_enq_ptr + c_ONE;
  assign w_deq_ptr_nxt = (r_deq_ptr == c_LAST) ? '0 : r_deq_ptr + c_ONE;

  // RAM port drive
  assign ram_W0_en   = w_do_enq;
  assign ram_W0_addr = r_enq_ptr;
  assign ram_W0_data = io_enq_bits;
  assign ram_R0_en   = io_deq_valid;
  assign ram_R0_addr = r_deq_ptr;
  assign io_deq_bits = ram_R0_data;

  // Occupancy. The wrapped case computes DEPTH + enq - deq modulo 2^ADDR_W.
  // These are the same low bits as a one-bit-wider sum followed by
  // truncation, so the extra bit is never built.
  always_comb begin
    w_count = '0;
    if (w_ptr_match) begin
      w_count = r_maybe_full ? c_DEPTH : '0;
    end else if (r_enq_ptr > r_deq_ptr) begin
      w_count = r_enq_ptr - r_deq_ptr;
    end else begin
      w_count = c_DEPTH + r_enq_ptr - r_deq_ptr;
    end
  end

  assign io_count = w_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_do_enq) begin
        r_enq_ptr <= w_enq_ptr_nxt;
      end
      if (w_do_deq) begin
        r_deq_ptr <= w_deq_ptr_nxt;
      end
      // maybe_full is set by an unmatched enqueue and cleared by an
      // unmatched dequeue. Balanced traffic leaves it unchanged.
      if (w_do_enq != w_do_deq) begin
        r_maybe_full <= w_do_enq;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_queue_ctrl_7x65.sv
// ============================================================================
// Module      : tb_queue_ctrl_7x65
// Description : Self-checking bench for queue_ctrl_7x65 with a behavioural
//               RAM and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_queue_ctrl_7x65;

  localparam int DEPTH = 7;
  localparam int WIDTH = 65;
  localparam int AW    = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_enq_valid;
  logic             io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits;
  logic             io_deq_valid;
  logic             io_deq_ready;
  logic [WIDTH-1:0] io_deq_bits;
  logic [AW-1:0]    io_count;
  logic [AW-1:0]    ram_W0_addr;
  logic             ram_W0_en;
  logic [WIDTH-1:0] ram_W0_data;
  logic [AW-1:0]    ram_R0_addr;
  logic             ram_R0_en;
  logic [WIDTH-1:0] ram_R0_data;

  queue_ctrl_7x65 dut (
    .clock        (clock),
    .reset        (reset),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_count     (io_count),
    .ram_W0_addr  (ram_W0_addr),
    .ram_W0_en    (ram_W0_en),
    .ram_W0_data  (ram_W0_data),
    .ram_R0_addr  (ram_R0_addr),
    .ram_R0_en    (ram_R0_en),
    .ram_R0_data  (ram_R0_data)
  );

  always #5 clock = ~clock;

  // Behavioural storage: synchronous write, combinational read.
  logic [WIDTH-1:0] mem [0:7];
  always @(posedge clock) if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
  assign ram_R0_data = mem[ram_R0_addr];

  // Reference model: FIFO contents plus the running totals since reset.
  logic [WIDTH-1:0] q[$];
  int enq_total = 0;
  int deq_total = 0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic             rst;
    logic             ev;
    logic [WIDTH-1:0] bits;
    logic             dr;
    logic [AW-1:0]    cnt;
    logic             er;
    logic             dv;
    logic             wen;
    logic [WIDTH-1:0] head;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [WIDTH-1:0] wv(input int i);
    return 65'h1_0000_0000_0000_0000 + 65'(i);
  endfunction

  function automatic logic [WIDTH-1:0] sv(input int i);
    return 65'h0_5555_0000_0000_0000 + 65'(i * 3);
  endfunction

  function automatic void add(input logic rst, ev, input logic [WIDTH-1:0] bits,
                              input logic dr, input int cnt,
                              input logic er, dv, wen,
                              input logic [WIDTH-1:0] head);
    vec_t v;
    v.rst = rst; v.ev = ev; v.bits = bits; v.dr = dr; v.cnt = AW'(cnt);
    v.er = er; v.dv = dv; v.wen = wen; v.head = head;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic mcheck;
    logic exp_er, exp_dv, exp_w;
    exp_er = !reset && (q.size() < DEPTH);
    exp_dv = !reset && (q.size() > 0);
    exp_w  = io_enq_valid && exp_er;
    cmp("m_enq_ready", 65'(io_enq_ready), 65'(exp_er));
    cmp("m_deq_valid", 65'(io_deq_valid), 65'(exp_dv));
    cmp("m_count", 65'(io_count), 65'(q.size()));
    cmp("m_w_en", 65'(ram_W0_en), 65'(exp_w));
    if (exp_w) begin
      cmp("m_w_addr", 65'(ram_W0_addr), 65'(enq_total % DEPTH));
      cmp("m_w_data", ram_W0_data, io_enq_bits);
    end
    if (exp_dv) begin
      cmp("m_deq_bits", io_deq_bits, q[0]);
      cmp("m_r_addr", 65'(ram_R0_addr), 65'(deq_total % DEPTH));
      cmp("m_r_en", 65'(ram_R0_en), 65'd1);
    end
  endtask

  task automatic drive(input logic r, ev, input logic [WIDTH-1:0] bits, input logic dr);
    reset = r; io_enq_valid = ev; io_enq_bits = bits; io_deq_ready = dr;
    #3;
    mcheck();
  endtask

  // Advance one clock and apply the same transfer rules to the model.
  task automatic tick;
    logic r, en, de;
    logic [WIDTH-1:0] b;
    r  = reset;
    de = !reset && io_deq_ready && (q.size() > 0);
    en = !reset && io_enq_valid && (q.size() < DEPTH);
    b  = io_enq_bits;
    @(posedge clock);
    if (r) begin
      q.delete();
      enq_total = 0;
      deq_total = 0;
    end else begin
      if (de) begin void'(q.pop_front()); deq_total++; end
      if (en) begin q.push_back(b); enq_total++; end
    end
    #1;
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; io_enq_valid = 1'b0; io_enq_bits = '0; io_deq_ready = 1'b0;
    @(posedge clock);
    #1;
    q.delete();

    // Fill to full, hold an extra write, then deq/enq from full.
    add(1, 1, wv(9), 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) add(0, 1, wv(i), 0, i, 1, (i > 0), 1, wv(0));
    for (int i = 0; i < 3; i++)     add(0, 1, wv(7), 0, 7, 0, 1, 0, wv(0));
    add(0, 1, wv(7), 1, 7, 0, 1, 0, wv(0));
    add(0, 1, wv(8), 1, 6, 1, 1, 1, wv(1));
    add(0, 0, '0,    0, 6, 1, 1, 0, wv(2));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ev, tbl[i].bits, tbl[i].dr);
      cmp("t_count", 65'(io_count), 65'(tbl[i].cnt));
      cmp("t_enq_ready", 65'(io_enq_ready), 65'(tbl[i].er));
      cmp("t_deq_valid", 65'(io_deq_valid), 65'(tbl[i].dv));
      cmp("t_w_en", 65'(ram_W0_en), 65'(tbl[i].wen));
      if (tbl[i].dv) cmp("t_head", io_deq_bits, tbl[i].head);
      tick();
    end

    // Continuous streaming: one word per cycle after one cycle of latency.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, sv(k), 1'b1);
      cmp("s_w_addr", 65'(ram_W0_addr), 65'(k % DEPTH));
      if (k > 0) begin
        cmp("s_bits", io_deq_bits, sv(k - 1));
        cmp("s_count", 65'(io_count), 65'd1);
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    cmp("s_last", io_deq_bits, sv(19));
    tick();

    // A single word, with no flow-through on an empty queue.
    drive(1'b0, 1'b1, 65'h0_DEAD_BEEF_CAFE_F00D, 1'b1);
    cmp("d_no_flow", 65'(io_deq_valid), 65'd0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    cmp("d_valid", 65'(io_deq_valid), 65'd1);
    cmp("d_bits", io_deq_bits, 65'h0_DEAD_BEEF_CAFE_F00D);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    cmp("d_empty", 65'(io_deq_valid), 65'd0);
    cmp("d_count", 65'(io_count), 65'd0);
    tick();

    // Wrapped occupancy: deq_ptr=5, enq_ptr=2, four entries.
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, wv(20 + i), 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, '0, 1'b1); tick(); end
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, sv(40 + i), 1'b0); tick(); end
    drive(1'b0, 1'b0, '0, 1'b0);
    cmp("w_count", 65'(io_count), 65'd4);
    cmp("w_r_addr", 65'(ram_R0_addr), 65'd5);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      cmp("w_drain_count", 65'(io_count), 65'(4 - i));
      cmp("w_drain_bits", io_deq_bits, sv(40 + i));
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    cmp("w_final_count", 65'(io_count), 65'd0);
    tick();

    // Reset in the middle of operation while a write is offered.
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, wv(30 + i), 1'b0); tick(); end
    drive(1'b1, 1'b1, wv(99), 1'b0);
    cmp("r_w_en", 65'(ram_W0_en), 65'd0);
    cmp("r_enq_ready", 65'(io_enq_ready), 65'd0);
    cmp("r_deq_valid", 65'(io_deq_valid), 65'd0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    cmp("r_count", 65'(io_count), 65'd0);
    cmp("r_deq_valid2", 65'(io_deq_valid), 65'd0);
    cmp("r_enq_ready2", 65'(io_enq_ready), 65'd1);
    tick();

    // Random traffic with enqueue-heavy and dequeue-heavy phases.
    for (int n = 0; n < 600; n++) begin
      logic r, ev, dr;
      logic [WIDTH-1:0] b;
      r  = ($urandom_range(0, 59) == 0);
      ev = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      dr = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      b  = {1'($urandom), 32'($urandom), 32'($urandom)};
      drive(r, ev, b, dr);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/queue_ctrl_7x65.md
Name: queue_ctrl_7x65

Overview:
- Ready/valid FIFO controller owning the 7-entry x 65-bit two-port data RAM.
- Drives the RAM write port from the enqueue side and the RAM read port for the dequeue side.
- Returns RAM read data as dequeue payload.
- Sits directly upstream of the RAM macro: all pointer, occupancy and handshake logic lives here; the RAM stays pure storage.

Parameters:
- DEPTH, 7, number of entries; need not be a power of two.
- WIDTH, 65, payload width in bits.
- ADDR_W, 3, RAM address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clock  input  1  single clock; also tied externally to RAM R0_clk/W0_clk.
- reset  input  1  synchronous, active-high.
- io_enq_valid  input  1  producer has data.
- io_enq_ready  output  1  queue can accept.
- io_enq_bits  input  WIDTH  enqueue payload.
- io_deq_valid  output  1  head entry available.
- io_deq_ready  input  1  consumer accepts head.
- io_deq_bits  output  WIDTH  head payload.
- io_count  output  ADDR_W  occupancy, 0..DEPTH.
- ram_W0_addr  output  ADDR_W  RAM write address.
- ram_W0_en  output  1  RAM write enable.
- ram_W0_data  output  WIDTH  RAM write data.
- ram_R0_addr  output  ADDR_W  RAM read address.
- ram_R0_en  output  1  RAM read enable.
- ram_R0_data  input  WIDTH  RAM read data; combinational from ram_R0_addr.

Behaviour:
- State: enq_ptr, deq_ptr (ADDR_W bits each, range 0..DEPTH-1) and maybe_full (1 bit).
- Reset: on a clock edge with reset=1, enq_ptr=0, deq_ptr=0, maybe_full=0.
- While reset=1: io_enq_ready=0, io_deq_valid=0, ram_W0_en=0.
- After reset: io_count=0, io_enq_ready=1, io_deq_valid=0.
- Status decode:
  - ptr_match = (enq_ptr == deq_ptr)
  - empty = ptr_match & ~maybe_full
  - full = ptr_match & maybe_full
- Handshake:
  - io_enq_ready = ~full & ~reset
  - io_deq_valid = ~empty & ~reset
  - do_enq = io_enq_valid & io_enq_ready
  - do_deq = io_deq_valid & io_deq_ready
  - The ready/valid relations are combinational from state only; no combinational path from valid to ready.
- RAM drive:
  - ram_W0_en = do_enq, ram_W0_addr = enq_ptr, ram_W0_data = io_enq_bits.
  - ram_R0_en = io_deq_valid, ram_R0_addr = deq_ptr.
  - io_deq_bits = ram_R0_data.
  - io_deq_bits is don't-care when io_deq_valid=0; X is permitted there.
- Pointer update: on do_enq, enq_ptr advances by 1; on do_deq, deq_ptr advances by 1. Each pointer wraps DEPTH-1 -> 0 explicitly, never through 2^ADDR_W; with DEPTH=7, index 7 is never generated.
- maybe_full: takes the value of do_enq when do_enq != do_deq; otherwise holds.
- Latency: data enqueued at edge N appears on io_deq_bits with io_deq_valid=1 in cycle N+1. There is no flow-through: the empty queue never presents same-cycle enq data.
- Simultaneous enq+deq:
  - When neither full nor empty: both fire, count unchanged, maybe_full unchanged.
  - Full: io_enq_ready=0, so only the deq fires; the slot frees next cycle. No pipe bypass.
  - Empty: io_deq_valid=0, so only the enq fires.
- io_count:
  - If ptr_match: DEPTH when maybe_full, else 0.
  - Else if enq_ptr > deq_ptr: enq_ptr - deq_ptr.
  - Else: DEPTH + enq_ptr - deq_ptr.
  - Computed at ADDR_W+1 bits and truncated; the result is always <= DEPTH.
- Reset mid-operation: all contents are logically discarded. Stale RAM data is never re-presented, because io_deq_valid is 0 until a new enqueue.
- Assertions for the bench: never do_enq when full; never do_deq when empty; pointers always < DEPTH; io_count == enqueues - dequeues since reset.

Test Plan:
- Reset, then enqueue 7 words 0x1_0000_0000_0000_0000 + i (i=0..6) with io_deq_ready=0 -> io_count steps 1..7, io_enq_ready=0 after 7th; 8th valid held 3 cycles is not written (ram_W0_en=0).
- From full, io_deq_ready=1 and io_enq_valid=1 together -> first cycle only deq fires (count 7->6); next cycle both fire (count stays 6); first dequeued word = i=0.
- Stream 20 sequential words with io_enq_valid=io_deq_ready=1 continuously -> output order identical, one per cycle after 1-cycle latency; ram_W0_addr sequence 0..6,0..6,0..5, never 7.
- Empty queue, io_deq_ready=1, single enqueue of 0x0_DEAD_BEEF_CAFE_F00D -> io_deq_valid=1 with that value exactly one cycle later, then io_deq_valid=0, io_count back to 0.
- Load 4 entries with deq_ptr advanced to 5 (enq_ptr wrapped to 2) -> io_count=4 via wrap formula; drain -> values in order, count 3,2,1,0.
- With 5 entries queued, assert reset 1 cycle while io_enq_valid=1 -> no write that cycle, io_count=0, io_deq_valid=0 next cycle, io_enq_ready=1 after reset drops.
